// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_arbiter
// Purpose  : Shares the GPR write port between pipeline WB and the long-latency
//            unit, tracks pending long-unit destinations and flags ID hazards.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we_,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lu_issue,
  input  logic [ADDR_W-1:0] lu_issue_rd,
  input  logic              lu_req,
  input  logic [ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ack,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  output logic              hazard,
  output logic              pipe_stall,
  output logic              gpr_we_,
  output logic [ADDR_W-1:0] gpr_wr_addr,
  output logic [DATA_W-1:0] gpr_wr_data
);

  localparam int         c_NREG       = 1 << ADDR_W;
  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_FORCE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_starve_cnt;
  logic [3:0]          w_starve_nxt;
  logic [c_NREG-1:0]   r_pending;
  logic [c_NREG-1:0]   w_pending_nxt;

  logic                w_pipe_v;
  logic                w_lu_v;
  logic                w_pipe_grant;
  logic                w_ack;
  logic                w_stall;
  logic                w_we_n;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_haz_rs1;
  logic                w_haz_rs2;
  logic                w_haz_rd;

  assign w_pipe_v = !pipe_we_ && (pipe_addr != '0);
  assign w_lu_v   = lu_req && (lu_rd != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ARB;
      r_starve_cnt <= '0;
      r_pending    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_pending    <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_pipe_grant = 1'b0;
    w_ack        = 1'b0;
    w_stall      = 1'b0;
    w_we_n       = 1'b1;
    w_addr       = '0;
    w_data       = '0;
    case (r_state)
      ST_ARB: begin
        if (w_pipe_v) begin
          w_pipe_grant = 1'b1;
          w_we_n       = 1'b0;
          w_addr       = pipe_addr;
          w_data       = pipe_data;
        end else if (lu_req) begin
          // A request to r0 is acknowledged but never reaches the register file
          w_ack = 1'b1;
          if (w_lu_v) begin
            w_we_n = 1'b0;
            w_addr = lu_rd;
            w_data = lu_data;
          end
        end
        w_starve_nxt = (lu_req && !w_ack) ? r_starve_cnt + 4'd1 : 4'd0;
        if (w_starve_nxt == c_STARVE_MAX) begin
          w_state_nxt = ST_FORCE;
        end
      end
      ST_FORCE: begin
        w_stall = w_pipe_v;
        if (lu_req) begin
          w_ack = 1'b1;
          if (w_lu_v) begin
            w_we_n = 1'b0;
            w_addr = lu_rd;
            w_data = lu_data;
          end
        end
        w_starve_nxt = 4'd0;
        w_state_nxt  = ST_ARB;
      end
      default: begin
        w_state_nxt  = ST_ARB;
        w_starve_nxt = 4'd0;
      end
    endcase
  end

  // Clear first so that a same-cycle issue to the acked register stays pending
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_ack && (lu_rd != '0)) begin
      w_pending_nxt[lu_rd] = 1'b0;
    end
    if (lu_issue && (lu_issue_rd != '0)) begin
      w_pending_nxt[lu_issue_rd] = 1'b1;
    end
  end

  // A same-cycle ack is bypassed to the reader by the register file
  assign w_haz_rs1 = (id_rs1 != '0) && r_pending[id_rs1] && !(w_ack && (lu_rd == id_rs1));
  assign w_haz_rs2 = (id_rs2 != '0) && r_pending[id_rs2] && !(w_ack && (lu_rd == id_rs2));
  assign w_haz_rd  = (id_rd  != '0) && r_pending[id_rd]  && !(w_ack && (lu_rd == id_rd));

  assign hazard      = reset && (w_haz_rs1 || w_haz_rs2 || w_haz_rd);
  assign lu_ack      = reset && w_ack;
  assign pipe_stall  = reset && w_stall;
  assign gpr_we_     = !reset || w_we_n;
  assign gpr_wr_addr = reset ? w_addr : '0;
  assign gpr_wr_data = reset ? w_data : '0;

  a_no_waw: assert property (@(posedge clk) disable iff (!reset)
    !(w_pipe_grant && r_pending[pipe_addr]));

  a_no_r0_write: assert property (@(posedge clk) disable iff (!reset)
    gpr_we_ || (gpr_wr_addr != '0));

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wb_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arbiter;

  localparam int c_STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we_;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_req;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ack;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        hazard;
  logic        pipe_stall;
  logic        gpr_we_;
  logic [4:0]  gpr_wr_addr;
  logic [31:0] gpr_wr_data;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit [31:0] m_pend;
  int        m_refused;
  bit        m_force;
  // model expectations for the current cycle
  bit        e_we_n, e_ack, e_stall, e_haz;
  bit [4:0]  e_addr;
  bit [31:0] e_data;

  gpr_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(c_STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .pipe_we_(pipe_we_), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_req(lu_req), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ack(lu_ack),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .hazard(hazard),
    .pipe_stall(pipe_stall),
    .gpr_we_(gpr_we_), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = '0; m_refused = 0; m_force = 1'b0;
  endtask

  task automatic model_eval();
    bit pv;
    logic [4:0] regs [3];
    pv = !pipe_we_ && pipe_addr != 0;
    e_we_n = 1; e_addr = 0; e_data = 0; e_ack = 0; e_stall = 0; e_haz = 0;
    if (!m_force && pv) begin
      e_we_n = 0; e_addr = pipe_addr; e_data = pipe_data;
    end else if (lu_req) begin
      e_ack = 1;
      if (lu_rd != 0) begin e_we_n = 0; e_addr = lu_rd; e_data = lu_data; end
    end
    if (m_force) e_stall = pv;
    regs[0] = id_rs1; regs[1] = id_rs2; regs[2] = id_rd;
    for (int i = 0; i < 3; i++)
      if (regs[i] != 0 && m_pend[regs[i]] && !(e_ack && lu_rd == regs[i])) e_haz = 1;
  endtask

  task automatic model_commit();
    if (m_force) begin
      m_force = 0; m_refused = 0;
    end else begin
      m_refused = (lu_req && !e_ack) ? m_refused + 1 : 0;
      if (m_refused == c_STARVE_MAX) m_force = 1;
    end
    if (e_ack && lu_rd != 0) m_pend[lu_rd] = 0;
    if (lu_issue && lu_issue_rd != 0) m_pend[lu_issue_rd] = 1;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (reset) model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we_ = 1; pipe_addr = 0; pipe_data = 0;
    lu_issue = 0; lu_issue_rd = 0; lu_req = 0; lu_rd = 0; lu_data = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  task automatic test_reset();
    reset = 0; model_reset(); idle_inputs();
    pipe_we_ = 0; pipe_addr = 3; pipe_data = 32'h11; lu_req = 1; lu_rd = 9; id_rs1 = 5;
    #2;
    n_checks++;
    if ({gpr_we_, gpr_wr_addr, gpr_wr_data} !== {1'b1, 5'd0, 32'd0}) begin
      n_errors++; $display("FAIL reset_port: got we_=%b addr=%0d data=%h want 1/0/0", gpr_we_, gpr_wr_addr, gpr_wr_data);
    end
    n_checks++;
    if ({lu_ack, pipe_stall, hazard} !== 3'b000) begin
      n_errors++; $display("FAIL reset_ctrl: got ack/stall/haz=%b%b%b want 000", lu_ack, pipe_stall, hazard);
    end
    @(posedge clk); #1;
    reset = 1; idle_inputs();
    lu_issue = 1; lu_issue_rd = 5;
    tick();
    idle_inputs(); lu_req = 1; lu_rd = 9; lu_data = 32'h99; id_rs1 = 5;
    #1;
    n_checks++;
    if (hazard !== 1'b1) begin n_errors++; $display("FAIL pend5_hazard: got %b want 1", hazard); end
    #2; reset = 0; model_reset();
    #1;
    n_checks++;
    if ({gpr_we_, gpr_wr_addr, lu_ack, pipe_stall, hazard} !== {1'b1, 5'd0, 3'b000}) begin
      n_errors++; $display("FAIL midcycle_reset: got we_=%b addr=%0d ack=%b stall=%b haz=%b want 1/0/0/0/0",
                           gpr_we_, gpr_wr_addr, lu_ack, pipe_stall, hazard);
    end
    @(posedge clk); #1;
    reset = 1; lu_req = 0;
    #1;
    n_checks++;
    if (hazard !== 1'b0) begin n_errors++; $display("FAIL post_reset_hazard: got %b want 0", hazard); end
    tick();
  endtask

  task automatic test_hazard_ack();
    idle_inputs(); lu_issue = 1; lu_issue_rd = 7;
    tick();
    idle_inputs(); id_rs1 = 7;
    for (int i = 0; i < 2; i++) begin
      #1; n_checks++;
      if (hazard !== 1'b1) begin n_errors++; $display("FAIL hazard_wait%0d: got %b want 1", i, hazard); end
      tick();
    end
    lu_req = 1; lu_rd = 7; lu_data = 32'hDEADBEEF;
    #1; n_checks++;
    if ({hazard, lu_ack, gpr_we_, gpr_wr_addr, gpr_wr_data} !== {1'b0, 1'b1, 1'b0, 5'd7, 32'hDEADBEEF}) begin
      n_errors++; $display("FAIL ack_cycle: got haz=%b ack=%b we_=%b addr=%0d data=%h want 0/1/0/7/deadbeef",
                           hazard, lu_ack, gpr_we_, gpr_wr_addr, gpr_wr_data);
    end
    tick();
    lu_req = 0;
    #1; n_checks++;
    if (hazard !== 1'b0) begin n_errors++; $display("FAIL after_ack_hazard: got %b want 0", hazard); end
    tick();
  endtask

  task automatic test_starvation();
    idle_inputs();
    pipe_we_ = 0; pipe_addr = 3; pipe_data = 32'h11; lu_req = 1; lu_rd = 9; lu_data = 32'h99;
    for (int i = 0; i < c_STARVE_MAX; i++) begin
      #1; n_checks++;
      if ({gpr_we_, gpr_wr_addr, lu_ack, pipe_stall} !== {1'b0, 5'd3, 2'b00}) begin
        n_errors++; $display("FAIL starve_pipe%0d: got we_=%b addr=%0d ack=%b stall=%b want 0/3/0/0",
                             i, gpr_we_, gpr_wr_addr, lu_ack, pipe_stall);
      end
      tick();
    end
    #1; n_checks++;
    if ({gpr_we_, gpr_wr_addr, gpr_wr_data, lu_ack, pipe_stall} !== {1'b0, 5'd9, 32'h99, 2'b11}) begin
      n_errors++; $display("FAIL force_slot: got we_=%b addr=%0d data=%h ack=%b stall=%b want 0/9/99/1/1",
                           gpr_we_, gpr_wr_addr, gpr_wr_data, lu_ack, pipe_stall);
    end
    tick();
    lu_req = 0;
    #1; n_checks++;
    if ({gpr_wr_addr, pipe_stall} !== {5'd3, 1'b0}) begin
      n_errors++; $display("FAIL pipe_resume: got addr=%0d stall=%b want 3/0", gpr_wr_addr, pipe_stall);
    end
    tick();
  endtask

  task automatic test_pipe_r0();
    idle_inputs();
    pipe_we_ = 0; pipe_addr = 0; pipe_data = 32'h77; lu_req = 1; lu_rd = 4; lu_data = 32'h44;
    #1; n_checks++;
    if ({lu_ack, gpr_we_, gpr_wr_addr, pipe_stall} !== {1'b1, 1'b0, 5'd4, 1'b0}) begin
      n_errors++; $display("FAIL pipe_r0: got ack=%b we_=%b addr=%0d stall=%b want 1/0/4/0",
                           lu_ack, gpr_we_, gpr_wr_addr, pipe_stall);
    end
    tick();
  endtask

  task automatic test_set_wins_and_rd0();
    idle_inputs(); lu_issue = 1; lu_issue_rd = 12;
    tick();
    lu_req = 1; lu_rd = 12; lu_data = 32'hABCD; id_rs1 = 12;
    #1; n_checks++;
    if ({lu_ack, gpr_wr_addr, gpr_wr_data, hazard} !== {1'b1, 5'd12, 32'hABCD, 1'b0}) begin
      n_errors++; $display("FAIL set_wins_ack: got ack=%b addr=%0d data=%h haz=%b want 1/12/abcd/0",
                           lu_ack, gpr_wr_addr, gpr_wr_data, hazard);
    end
    tick();
    lu_issue = 0; lu_req = 0;
    #1; n_checks++;
    if (hazard !== 1'b1) begin n_errors++; $display("FAIL set_wins_pending: got %b want 1", hazard); end
    tick();
    lu_req = 1; lu_rd = 0; lu_data = 32'h55;
    #1; n_checks++;
    if ({lu_ack, gpr_we_, hazard} !== 3'b111) begin
      n_errors++; $display("FAIL rd0_drop: got ack=%b we_=%b haz=%b want 1/1/1", lu_ack, gpr_we_, hazard);
    end
    tick();
    lu_req = 0;
    #1; n_checks++;
    if (hazard !== 1'b1) begin n_errors++; $display("FAIL rd0_scoreboard: got %b want 1", hazard); end
    lu_req = 1; lu_rd = 12; lu_data = 32'h1212;
    tick();
    lu_req = 0;
    #1; n_checks++;
    if (hazard !== 1'b0) begin n_errors++; $display("FAIL cleanup_12: got %b want 0", hazard); end
    tick();
  endtask

  task automatic test_random();
    bit prev_ack = 0;
    idle_inputs();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!lu_req || prev_ack) begin
        lu_req = ($urandom_range(0, 2) != 0);
        lu_rd = 5'($urandom_range(0, 31)); lu_data = $urandom;
      end
      pipe_we_ = ($urandom_range(0, 4) == 0);
      pipe_addr = 5'($urandom_range(0, 31)); pipe_data = $urandom;
      if (m_pend[pipe_addr]) pipe_addr = 0;
      lu_issue = ($urandom_range(0, 3) == 0); lu_issue_rd = 5'($urandom_range(0, 31));
      id_rs1 = 5'($urandom_range(0, 31)); id_rs2 = 5'($urandom_range(0, 31));
      id_rd = 5'($urandom_range(0, 31));
      #1;
      model_eval();
      n_checks++;
      if ({gpr_we_, gpr_wr_addr, gpr_wr_data} !== {e_we_n, e_addr, e_data}) begin
        n_errors++; $display("FAIL rand_port cyc%0d: got we_=%b addr=%0d data=%h want %b/%0d/%h",
                             cyc, gpr_we_, gpr_wr_addr, gpr_wr_data, e_we_n, e_addr, e_data);
      end
      n_checks++;
      if ({lu_ack, pipe_stall, hazard} !== {e_ack, e_stall, e_haz}) begin
        n_errors++; $display("FAIL rand_ctrl cyc%0d: got ack/stall/haz=%b%b%b want %b%b%b",
                             cyc, lu_ack, pipe_stall, hazard, e_ack, e_stall, e_haz);
      end
      prev_ack = e_ack;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_hazard_ack();
    test_starvation();
    test_pipe_r0();
    test_set_wins_and_rd0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single write port of the general purpose register file between two writers: the in-order pipeline writeback and the multi-cycle long-latency unit (mul/div).
- Keeps a 32-entry pending scoreboard for long-unit destinations and raises an ID-stage hazard.
- Guarantees the long unit is never starved, by forcing a pipeline writeback stall slot.
- Sits between the WB stage, the long unit and the register file write port.

Parameters:
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register data width
- STARVE_MAX, 4, consecutive refused cycles of lu_req before a forced slot (range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pipe_we_  in  1  pipeline writeback enable, active-low
- pipe_addr  in  ADDR_W  pipeline writeback register
- pipe_data  in  DATA_W  pipeline writeback data
- lu_issue  in  1  long-unit op issued this cycle
- lu_issue_rd  in  ADDR_W  destination of issued op
- lu_req  in  1  long-unit result valid; lu_rd/lu_data held stable until lu_ack
- lu_rd  in  ADDR_W  result destination
- lu_data  in  DATA_W  result data
- lu_ack  out  1  result written this cycle
- id_rs1  in  ADDR_W  ID-stage source 1
- id_rs2  in  ADDR_W  ID-stage source 2
- id_rd  in  ADDR_W  ID-stage destination
- hazard  out  1  ID instruction must stall
- pipe_stall  out  1  pipeline writeback refused this cycle; WB holds its values
- gpr_we_  out  1  register file write enable, active-low
- gpr_wr_addr  out  ADDR_W  register file write address
- gpr_wr_data  out  DATA_W  register file write data

Behaviour:
- Reset (async, reset low): pending=0, starve_cnt=0, FSM=ARB. Outputs forced while reset is low: gpr_we_=1, gpr_wr_addr=0, gpr_wr_data=0, lu_ack=0, pipe_stall=0, hazard=0. An in-flight lu result is discarded; the long unit is reset by the same signal.
- Write valid terms: pipe_v = (pipe_we_==0) && pipe_addr!=0; lu_v = lu_req && lu_rd!=0. lu_req with lu_rd==0 is acked and dropped with gpr_we_=1.
- Port mux is combinational, zero latency. The register file captures the write on the next clk edge.
- FSM ARB:
  - pipe_v present: grant pipe (gpr_we_=0, pipe_addr/pipe_data).
  - Else lu_v present: grant lu (lu_ack=1).
  - Else gpr_we_=1.
  - starve_cnt increments on each cycle with lu_req=1 and lu_ack=0; it clears on lu_ack or when lu_req=0.
  - When starve_cnt reaches STARVE_MAX at a clock edge, go to FORCE.
- FSM FORCE (exactly one cycle):
  - lu has priority; lu_ack=1 if lu_req.
  - pipe_stall=1 whenever pipe_v; the pipeline holds WB for that cycle.
  - Return to ARB; starve_cnt=0.
  - If lu_req dropped, FORCE is still consumed.
- pipe_stall is 0 in ARB.
- Scoreboard update on each clk edge:
  - Set pending[lu_issue_rd] if lu_issue && lu_issue_rd!=0.
  - Clear pending[lu_rd] if lu_ack.
  - Set and clear of the same register in the same cycle: set wins.
- hazard (combinational): for any of r in {id_rs1, id_rs2, id_rd}, hazard=1 if r!=0 && pending[r] && !(lu_ack && lu_rd==r). A same-cycle ack is not a hazard because the register file bypasses write data to reads.
- Invariant (assertion): pipe write to a pending register never occurs; hazard on id_rd prevents WAW.
- At most one write per cycle; gpr_we_=0 implies gpr_wr_addr!=0.

Test Plan:
- Reset low mid-cycle with pending[5]=1, lu_req=1 -> outputs go to reset values immediately; after release, hazard=0 for id_rs1=5.
- lu_issue rd=7, then id_rs1=7 -> hazard=1 until the lu_ack cycle (lu_rd=7, lu_data=0xDEADBEEF). In that cycle hazard=0, gpr_we_=0, addr=7, data=0xDEADBEEF.
- pipe_v every cycle (addr=3, data=0x11) with lu_req rd=9 -> 4 cycles of pipe grants with lu_ack=0. Next cycle is FORCE: lu_ack=1, gpr_wr_addr=9, pipe_stall=1. Then the pipe resumes.
- pipe_we_=0, pipe_addr=0 with lu_req rd=4 -> lu granted the same cycle, gpr_wr_addr=4, pipe_stall=0.
- lu_issue rd=12 in the same cycle as lu_ack rd=12 -> pending[12]=1 afterwards (set wins), and the old data is written.
- lu_req with lu_rd=0 -> lu_ack=1, gpr_we_=1, no scoreboard change.
